class_fifo_writer: RTL and testbench
====================================

Name: class_fifo_writer

Overview:
- Ingress-side writer that feeds the four class FIFOs which the output arbiter later pops.
- Accepts 12-bit words from the upstream source with a valid/ready handshake and buffers them in a 2-entry in-order buffer.
- Steers each word into the class FIFO selected by bits [11:10], honouring each FIFO's almost_full backpressure.
- Words are never dropped. Head-of-line blocking is intended, so per-source ordering is preserved.

Parameters:
- WORD_SIZE, 12, word width: [11:10] class, [9:8] destination, [7:0] payload.
- BUF_DEPTH, 2, ingress buffer entries; fixed at 2 for this release.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word valid.
- in_data  in  WORD_SIZE  upstream word.
- in_ready  out  1  buffer can accept a word this cycle.
- fifos_almost_full  in  4  almost_full flags of class FIFOs 0..3.
- fifos_push  out  4  one-hot push strobe to class FIFO; registered.
- fifo_data_out  out  WORD_SIZE  word presented to the class FIFOs; registered.
- stall  out  1  head word blocked by its target's almost_full; registered.
- class_cnt  out  32  only with CLASS_STATS_EN; 4 x 8-bit per-class push counters, class n in [8n+7:8n].

Behaviour:
- Reset, asynchronous and active-high:
  - buffer emptied, state IDLE.
  - fifos_push=0, fifo_data_out=0, stall=0, class_cnt=0.
  - in_ready=0 while reset is high.
- Reset may assert mid-transfer; any buffered words are discarded.
- Handshake:
  - in_ready = !reset && (buffer count < BUF_DEPTH), computed from the registered count.
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_data is sampled only on a transfer.
- Dispatch decision, made each cycle on the registered buffer head:
  - c = head[11:10].
  - If the buffer is non-empty and fifos_almost_full[c]==0, then at the next edge fifos_push = 1<<c, fifo_data_out = head, and the head is popped.
  - Otherwise fifos_push=0 and fifo_data_out holds its last value.
- fifos_push is asserted for exactly one cycle per word; at most one bit is set in any cycle.
- Latency: a word accepted at edge N into an empty buffer, with its target not almost_full, is pushed at edge N+1 (push visible during cycle N+1..N+2).
- Throughput: 1 word/cycle sustained when targets are free.
- A simultaneous accept and dispatch in the same cycle is legal; the count is unchanged and in_ready stays 1.
- Full buffer (count=2): in_ready=0. An accept that coincides with a dispatch is not permitted because in_ready is computed from the registered count.
- Empty buffer: no push; fifos_almost_full is ignored.
- All four almost_full flags set: no pushes; the buffer fills, then in_ready drops.
- State machine, one registered state:
  - IDLE: buffer empty. Goes to SEND on accept.
  - SEND: buffer non-empty and head dispatchable. Goes to BLOCKED when the next head's target is almost_full. Goes to IDLE when empty after pop with no accept.
  - BLOCKED: head held, stall=1. Goes to SEND in the cycle after fifos_almost_full[c] falls.
  - stall = (state==BLOCKED).
- Word integrity: words are pushed in acceptance order, bit-exact; the class field is never modified.

Optional Feature:
- Macro CLASS_STATS_EN.
- Defined:
  - class_cnt port exists.
  - Counter n increments on every edge where fifos_push[n] is asserted.
  - 8-bit, wraps 255->0.
  - Cleared by reset.
- Undefined: class_cnt port and counters absent; all other behaviour identical.

Decomposition:
- Shared package class_fifo_pkg holds:
  - WORD_SIZE.
  - CLASS_MSB=11, CLASS_LSB=10, DEST_MSB=9, DEST_LSB=8.
  - NUM_CLASSES=4.
  - State encoding IDLE=2'd0, SEND=2'd1, BLOCKED=2'd2.
  - This package is also used by the arbiter side.
- One sub-module, word_skid_buf2: a 2-entry in-order buffer with push/pop, head, count, and asynchronous reset.
- The top level holds the dispatch logic, the FSM, the output registers and the optional counters.

Test Plan:
1. Reset: assert reset asynchronously mid-cycle with 2 words buffered -> outputs 0 immediately, in_ready=0; after release in_ready=1 and no push of the discarded words.
2. Single word: in_data=12'h4A5 (class 1), almost_full=4'b0000 -> one cycle later fifos_push=4'b0010, fifo_data_out=12'h4A5, then fifos_push=0.
3. Streaming: classes 0,1,2,3 on consecutive cycles, no backpressure -> fifos_push sequence 0001,0010,0100,1000 back-to-back, in_ready constantly 1.
4. Backpressure: almost_full=4'b0100, send 12'h8FF (class 2) then 12'h011 (class 0):
   - stall=1, no push, buffer fills, in_ready=0.
   - Release bit 2 -> push 0100/12'h8FF, then 0001/12'h011, in order.
5. All almost_full=4'b1111 with 3 words offered -> exactly 2 accepted, no pushes; clear flags -> both pushed, then the third is accepted.
6. CLASS_STATS_EN: push 257 class-3 words -> class_cnt[31:24]=8'd1; other fields 0.

Source files
------------

// File: rtl/class_fifo_pkg.sv
// ============================================================================
// class_fifo_pkg : word layout, class count and writer FSM encoding shared by
//                  the class FIFO writer and the output arbiter.
// Revision 1.0
// ============================================================================
`default_nettype none

package class_fifo_pkg;

  localparam int WORD_SIZE   = 12;
  localparam int BUF_DEPTH   = 2;
  localparam int CLASS_MSB   = 11;
  localparam int CLASS_LSB   = 10;
  localparam int DEST_MSB    = 9;
  localparam int DEST_LSB    = 8;
  localparam int NUM_CLASSES = 4;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  typedef logic [WORD_SIZE-1:0] word_t;

  function automatic logic [1:0] word_class(input word_t w);
    return w[CLASS_MSB:CLASS_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/word_skid_buf2.sv
// ============================================================================
// word_skid_buf2 : 2-entry in-order word buffer; entry 0 is always the head.
// Revision 1.0
// ============================================================================
`default_nettype none

module word_skid_buf2
  import class_fifo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  word_t       din,
  output word_t       head,
  output word_t       second,
  output logic [1:0]  count
);

  word_t      r_entry0;
  word_t      r_entry1;
  logic [1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_entry0 <= '0;
      r_entry1 <= '0;
      r_count  <= 2'd0;
    end else begin
      // Shift on pop so the head stays in entry 0; a concurrent push lands
      // in the slot freed behind the new head.
      case ({push, pop})
        2'b01: begin
          r_entry0 <= r_entry1;
          r_count  <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) r_entry0 <= din;
          else                 r_entry1 <= din;
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_entry0 <= din;
          end else begin
            r_entry0 <= r_entry1;
            r_entry1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head   = r_entry0;
  assign second = r_entry1;
  assign count  = r_count;

endmodule

`default_nettype wire

// File: rtl/class_fifo_writer.sv
// ============================================================================
// class_fifo_writer : buffers upstream words and steers each into the class
//                     FIFO named by its class field, honouring almost_full.
// Optional per-class push counters: define CLASS_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module class_fifo_writer
  import class_fifo_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WORD_SIZE-1:0]   in_data,
  output logic                   in_ready,
  input  logic [NUM_CLASSES-1:0] fifos_almost_full,
  output logic [NUM_CLASSES-1:0] fifos_push,
  output logic [WORD_SIZE-1:0]   fifo_data_out,
  output logic                   stall
`ifdef CLASS_STATS_EN
  ,
  output logic [31:0]            class_cnt
`endif
);

  word_t                  w_head;
  word_t                  w_second;
  logic [1:0]             w_count;
  logic                   w_accept;
  logic                   w_dispatch;
  logic [1:0]             w_cls;
  logic [NUM_CLASSES-1:0] w_onehot;
  word_t                  w_next_head;
  logic                   w_next_empty;
  logic [1:0]             w_next_state;

  logic [1:0]             r_state;
  logic [NUM_CLASSES-1:0] r_push;
  word_t                  r_data;

  assign in_ready   = !reset && (w_count < 2'(BUF_DEPTH));
  assign w_accept   = in_valid && in_ready;
  assign w_cls      = word_class(w_head);
  assign w_onehot   = NUM_CLASSES'(1) << w_cls;
  assign w_dispatch = (w_count != 2'd0) && !fifos_almost_full[w_cls];

  word_skid_buf2 u_buf (
    .clk    (clk),
    .reset  (reset),
    .push   (w_accept),
    .pop    (w_dispatch),
    .din    (in_data),
    .head   (w_head),
    .second (w_second),
    .count  (w_count)
  );

  // Predict the head after this edge so the FSM tracks whether it will block.
  always_comb begin
    w_next_head  = w_head;
    w_next_empty = 1'b0;
    if (w_dispatch) begin
      if (w_count == 2'd2)  w_next_head = w_second;
      else if (w_accept)    w_next_head = in_data;
      else                  w_next_empty = 1'b1;
    end else if (w_count == 2'd0) begin
      if (w_accept) w_next_head = in_data;
      else          w_next_empty = 1'b1;
    end
    w_next_state = SEND;
    if (w_next_empty)
      w_next_state = IDLE;
    else if (fifos_almost_full[word_class(w_next_head)])
      w_next_state = BLOCKED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_push  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next_state;
      r_push  <= w_dispatch ? w_onehot : '0;
      if (w_dispatch) r_data <= w_head;
    end
  end

  assign fifos_push    = r_push;
  assign fifo_data_out = r_data;
  assign stall         = (r_state == BLOCKED);

`ifdef CLASS_STATS_EN
  generate
    for (genvar n = 0; n < NUM_CLASSES; n++) begin : g_cnt
      logic [7:0] r_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_cnt <= 8'd0;
        else if (r_push[n]) r_cnt <= r_cnt + 8'd1;
      end
      assign class_cnt[8*n +: 8] = r_cnt;
    end
  endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_class_fifo_writer.sv
// ============================================================================
// tb_class_fifo_writer : directed self-checking bench for class_fifo_writer.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_class_fifo_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic [3:0]  fifos_almost_full;
  logic [3:0]  fifos_push;
  logic [11:0] fifo_data_out;
  logic        stall;
`ifdef CLASS_STATS_EN
  logic [31:0] class_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  class_fifo_writer dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .fifos_almost_full (fifos_almost_full),
    .fifos_push        (fifos_push),
    .fifo_data_out     (fifo_data_out),
    .stall             (stall)
`ifdef CLASS_STATS_EN
    ,
    .class_cnt         (class_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    fifos_almost_full = 4'b0000;
    tick();
    tick();
    check("rst_push", 32'(fifos_push), 32'h0);
    check("rst_data", 32'(fifo_data_out), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_ready", 32'(in_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("rel_ready", 32'(in_ready), 32'h1);

    // Single word, class 1
    tick();
    in_valid = 1'b1;
    in_data  = 12'h4A5;
    tick();
    in_valid = 1'b0;
    check("single_lat0", 32'(fifos_push), 32'h0);
    tick();
    check("single_push", 32'(fifos_push), 32'h2);
    check("single_data", 32'(fifo_data_out), 32'h4A5);
    tick();
    check("single_end", 32'(fifos_push), 32'h0);
    check("single_hold", 32'(fifo_data_out), 32'h4A5);

    // Streaming classes 0..3 back-to-back
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = {2'(i), 2'b01, 8'(8'h10 + i)};
      tick();
      check("stream_ready", 32'(in_ready), 32'h1);
      if (i > 0) begin
        check("stream_push", 32'(fifos_push), 32'(4'b0001 << (i - 1)));
        check("stream_data", 32'(fifo_data_out), 32'({2'(i - 1), 2'b01, 8'(8'h10 + i - 1)}));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_last", 32'(fifos_push), 32'h8);
    check("stream_ldata", 32'(fifo_data_out), 32'hD13);
    tick();
    check("stream_idle", 32'(fifos_push), 32'h0);

    // Backpressure on class 2
    fifos_almost_full = 4'b0100;
    in_valid = 1'b1;
    in_data  = 12'h8FF;
    tick();
    check("bp_stall", 32'(stall), 32'h1);
    check("bp_ready1", 32'(in_ready), 32'h1);
    in_data = 12'h011;
    tick();
    in_valid = 1'b0;
    check("bp_full", 32'(in_ready), 32'h0);
    check("bp_nopush", 32'(fifos_push), 32'h0);
    tick();
    check("bp_stall2", 32'(stall), 32'h1);
    check("bp_nopush2", 32'(fifos_push), 32'h0);
    fifos_almost_full = 4'b0000;
    tick();
    check("bp_push1", 32'(fifos_push), 32'h4);
    check("bp_data1", 32'(fifo_data_out), 32'h8FF);
    check("bp_unstall", 32'(stall), 32'h0);
    tick();
    check("bp_push2", 32'(fifos_push), 32'h1);
    check("bp_data2", 32'(fifo_data_out), 32'h011);
    tick();
    check("bp_idle", 32'(fifos_push), 32'h0);

    // All almost_full, three words offered
    fifos_almost_full = 4'b1111;
    in_valid = 1'b1;
    in_data  = 12'h412;
    tick();
    in_data  = 12'h823;
    tick();
    in_data  = 12'hC34;
    check("af_full", 32'(in_ready), 32'h0);
    tick();
    check("af_nopush", 32'(fifos_push), 32'h0);
    check("af_ready", 32'(in_ready), 32'h0);
    tick();
    check("af_nopush2", 32'(fifos_push), 32'h0);
    fifos_almost_full = 4'b0000;
    tick();
    check("af_push1", 32'(fifos_push), 32'h2);
    check("af_data1", 32'(fifo_data_out), 32'h412);
    tick();
    in_valid = 1'b0;
    check("af_push2", 32'(fifos_push), 32'h4);
    check("af_data2", 32'(fifo_data_out), 32'h823);
    tick();
    check("af_push3", 32'(fifos_push), 32'h8);
    check("af_data3", 32'(fifo_data_out), 32'hC34);
    tick();
    check("af_idle", 32'(fifos_push), 32'h0);

    // Reset mid-cycle with two words buffered
    fifos_almost_full = 4'b1111;
    in_valid = 1'b1;
    in_data  = 12'h155;
    tick();
    in_data  = 12'h266;
    tick();
    in_valid = 1'b0;
    check("mr_full", 32'(in_ready), 32'h0);
    check("mr_stall", 32'(stall), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_ready", 32'(in_ready), 32'h0);
    check("mr_push", 32'(fifos_push), 32'h0);
    check("mr_data", 32'(fifo_data_out), 32'h0);
    check("mr_stall0", 32'(stall), 32'h0);
    tick();
    reset = 1'b0;
    fifos_almost_full = 4'b0000;
    #1;
    check("mr_rel_ready", 32'(in_ready), 32'h1);
    tick();
    check("mr_nopush1", 32'(fifos_push), 32'h0);
    tick();
    check("mr_nopush2", 32'(fifos_push), 32'h0);
    check("mr_data2", 32'(fifo_data_out), 32'h0);

`ifdef CLASS_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      in_valid = 1'b1;
      in_data  = {2'b11, 2'b00, 8'(i)};
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("stats_cnt", class_cnt, 32'h0100_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
